pio_sw_ctrl: RTL and testbench
==============================

# pio_sw_ctrl

Switch-input controller for the 10-bit slide-switch PIO path on the SOPC Avalon bus. It synchronizes and debounces the raw switch pins and presents a stable data value. It records per-bit edges in a sticky capture register and raises a maskable interrupt to the Nios II CPU. It is an Avalon-MM slave with read latency 1 and sits between the board switch pins and the system interconnect.

## Interface
- WIDTH, 10, number of switch bits
- PRESCALE, 50000, clk cycles per debounce sample tick (≥2)
- DEBOUNCE_TICKS, 4, consecutive ticks a changed level must persist before acceptance (≥1)

- clk  input  1  system clock
- reset_n  input  1  reset: asynchronous, active-low; clock clk
- address  input  2  Avalon word address
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe, qualified by chipselect
- writedata  input  WIDTH  write data
- readdata  output  WIDTH  registered read data
- in_port  input  WIDTH  raw asynchronous switch pins
- irq  output  1  level interrupt to CPU

## Operation
- Register map:
  - 0 DATA: RO, debounced value.
  - 1: reads 0, writes ignored.
  - 2 IRQ_MASK: RW.
  - 3 EDGE_CAPTURE: read; write-1-to-clear.
- Synchronizer: 2-FF per bit on in_port producing sync[WIDTH-1:0].
- Prescaler: counter 0..PRESCALE-1, wraps. tick=1 for one cycle when counter==PRESCALE-1.
- Per-bit debounce, states STABLE / PENDING:
  - STABLE, sync==deb: count=0.
  - STABLE→PENDING: when sync!=deb; count stays 0 until next tick.
  - PENDING, on tick with sync!=deb: count+1.
  - Acceptance: when count+1 == DEBOUNCE_TICKS, deb<=sync, count<=0, back to STABLE.
  - PENDING, sync==deb on any cycle: count<=0, back to STABLE (glitch rejected).
  - count width is $clog2(DEBOUNCE_TICKS+1); it never exceeds DEBOUNCE_TICKS-1.
- Edge capture:
  - Bit i set on the clock edge where deb[i] changes (either direction).
  - Write to address 3 clears bits where writedata=1.
  - Same-cycle set and clear on one bit: set wins.
- irq = |(EDGE_CAPTURE & IRQ_MASK), combinational from registers.
- Writes to addresses 0 and 1 are ignored.

## Timing
- Reset values: readdata=0, irq=0, deb=0, EDGE_CAPTURE=0, IRQ_MASK=0, prescaler=0, all counts=0.
- Switches already high at reset release are debounced from 0 and generate a captured edge.
- readdata is loaded every clk with the mux of the current address, independent of chipselect, so read latency is 1 cycle.
- Register writes take effect at the clk edge where chipselect=1 and write_n=0.
- Input-to-deb latency: 2 sync cycles, plus DEBOUNCE_TICKS ticks, plus up to PRESCALE-1 cycles of tick phase.
- deb-change to EDGE_CAPTURE: 0 extra cycles, same edge.
- irq follows EDGE_CAPTURE or IRQ_MASK in the same cycle.
- Reset asserted mid-debounce discards all pending state immediately.

## Structure
- Shared package pio_sw_pkg holds address constants ADDR_DATA=0, ADDR_RSVD=1, ADDR_IRQ_MASK=2, ADDR_EDGE=3.
- Sub-module pio_sw_debounce: one bit, containing sync FFs, counter and deb. It is instantiated WIDTH times with a shared tick.
- The prescaler, register file and read mux live in the top module.

## Test plan
Bench parameters: WIDTH=10, PRESCALE=4, DEBOUNCE_TICKS=3.
- Clean press: in_port 0x000→0x001 held. Within 2+12+3 cycles DATA reads 0x001, EDGE_CAPTURE reads 0x001, and irq=0 because mask=0.
- Glitch reject: bit 5 high for 5 cycles, then low. DATA and EDGE_CAPTURE stay 0x000.
- Interrupt flow: write IRQ_MASK=0x001, then press bit 0; irq=1 once captured. Write 0x001 to address 3; irq=0 the next cycle. Release bit 0; irq=1 again after debounce.
- Clear/set collision: time a write of 0x002 to address 3 on the cycle deb[1] toggles. EDGE_CAPTURE bit 1 remains 1.
- Reset mid-debounce: in_port=0x3FF with debounce partly complete, pulse reset_n low for 1 cycle. readdata=0 and irq=0 immediately. DATA then reaches 0x3FF after a full debounce, and EDGE_CAPTURE=0x3FF.
- Read mux: address 1 reads 0x000. Write 0x155 to IRQ_MASK and read back 0x155 one cycle after the address is presented.

Source files
------------

// File: rtl/pio_sw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pio_sw_pkg
// Description : Shared register addresses and debounce state encoding for the
//               slide-switch PIO controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pio_sw_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_RSVD     = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE     = 2'd3;

    typedef enum logic [0:0] {
        DB_STABLE  = 1'b0,
        DB_PENDING = 1'b1
    } db_state_t;

endpackage
`default_nettype wire

// File: rtl/pio_sw_debounce.sv
`default_nettype none
// ============================================================================
// Module      : pio_sw_debounce
// Description : One-bit 2-FF synchronizer plus tick-based debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
module pio_sw_debounce
    import pio_sw_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_tick,
    input  logic i_pin,
    output logic o_deb,
    output logic o_accept
);

    localparam int                  c_cnt_w = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(DEBOUNCE_TICKS);

    logic               r_sync0;
    logic               r_sync1;
    logic               r_deb;
    logic               w_deb_nxt;
    logic               w_accept;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [c_cnt_w-1:0] w_cnt_inc;
    db_state_t          r_state;
    db_state_t          w_state_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_deb   <= 1'b0;
            r_cnt   <= '0;
            r_state <= DB_STABLE;
        end else begin
            r_sync0 <= i_pin;
            r_sync1 <= r_sync0;
            r_deb   <= w_deb_nxt;
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_deb_nxt   = r_deb;
        w_accept    = 1'b0;
        w_cnt_inc   = r_cnt + c_cnt_w'(1);
        case (r_state)
            DB_STABLE: begin
                w_cnt_nxt = '0;
                if (r_sync1 != r_deb)
                    w_state_nxt = DB_PENDING;
            end
            DB_PENDING: begin
                if (r_sync1 == r_deb) begin
                    // Level went back before acceptance: treat as a glitch.
                    w_cnt_nxt   = '0;
                    w_state_nxt = DB_STABLE;
                end else if (i_tick) begin
                    if (w_cnt_inc == c_last) begin
                        w_deb_nxt   = r_sync1;
                        w_cnt_nxt   = '0;
                        w_accept    = 1'b1;
                        w_state_nxt = DB_STABLE;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = DB_STABLE;
            end
        endcase
    end

    assign o_deb    = r_deb;
    assign o_accept = w_accept;

endmodule
`default_nettype wire

// File: rtl/pio_sw_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pio_sw_ctrl
// Description : Avalon-MM slide-switch PIO with debounce, edge capture and IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
module pio_sw_ctrl
    import pio_sw_pkg::*;
#(
    parameter int WIDTH          = 10,
    parameter int PRESCALE       = 50000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int                 c_pre_w    = $clog2(PRESCALE);
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(PRESCALE - 1);

    logic [c_pre_w-1:0] r_pre;
    logic               w_tick;
    logic [WIDTH-1:0]   w_deb;
    logic [WIDTH-1:0]   w_accept;
    logic [WIDTH-1:0]   r_edge;
    logic [WIDTH-1:0]   r_mask;
    logic [WIDTH-1:0]   r_readdata;
    logic [WIDTH-1:0]   w_rd_mux;
    logic [WIDTH-1:0]   w_edge_clr;
    logic               w_wr;

    assign w_tick = (r_pre == c_pre_last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_pre <= '0;
        else if (w_tick)
            r_pre <= '0;
        else
            r_pre <= r_pre + c_pre_w'(1);
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            pio_sw_debounce #(
                .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
            ) u_deb (
                .clk      (clk),
                .reset_n  (reset_n),
                .i_tick   (w_tick),
                .i_pin    (in_port[gi]),
                .o_deb    (w_deb[gi]),
                .o_accept (w_accept[gi])
            );
        end
    endgenerate

    assign w_wr       = chipselect & ~write_n;
    assign w_edge_clr = (w_wr && address == ADDR_EDGE) ? writedata : '0;

    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:     w_rd_mux = w_deb;
            ADDR_RSVD:     w_rd_mux = '0;
            ADDR_IRQ_MASK: w_rd_mux = r_mask;
            ADDR_EDGE:     w_rd_mux = r_edge;
            default:       w_rd_mux = '0;
        endcase
    end

    // Capture set is OR'd after the clear so a coincident new edge survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge     <= '0;
            r_mask     <= '0;
            r_readdata <= '0;
        end else begin
            r_edge     <= (r_edge & ~w_edge_clr) | w_accept;
            r_readdata <= w_rd_mux;
            if (w_wr && address == ADDR_IRQ_MASK)
                r_mask <= writedata;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edge & r_mask);

endmodule
`default_nettype wire

// File: tb/tb_pio_sw_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pio_sw_ctrl
// Description : Directed self-checking bench for pio_sw_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_sw_ctrl;

    localparam int WIDTH          = 10;
    localparam int PRESCALE       = 4;
    localparam int DEBOUNCE_TICKS = 3;
    localparam int SETTLE         = 2 + PRESCALE * DEBOUNCE_TICKS + 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] readdata;
    logic [WIDTH-1:0] in_port;
    logic             irq;

    int checks   = 0;
    int failures = 0;
    logic [1:0] r_phase;
    logic [WIDTH-1:0] v;

    pio_sw_ctrl #(
        .WIDTH          (WIDTH),
        .PRESCALE       (PRESCALE),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Reference prescaler phase, used only to time the set/clear collision.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_phase <= 2'd0;
        else
            r_phase <= r_phase + 2'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [WIDTH-1:0] d);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(posedge clk);
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [WIDTH-1:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_readdata", readdata, 0);
        check("reset_irq", irq, 0);
        @(negedge clk);
        reset_n = 1'b1;

        bus_read(2'd0, v); check("reset_data", v, 10'h000);
        bus_read(2'd2, v); check("reset_mask", v, 10'h000);
        bus_read(2'd3, v); check("reset_edge", v, 10'h000);

        // Clean press of bit 0
        @(negedge clk); in_port = 10'h001;
        wait_cycles(SETTLE);
        bus_read(2'd0, v); check("press_data", v, 10'h001);
        bus_read(2'd3, v); check("press_edge", v, 10'h001);
        check("press_irq_masked", irq, 0);

        @(negedge clk); in_port = 10'h000;
        wait_cycles(SETTLE);
        bus_read(2'd0, v); check("release_data", v, 10'h000);
        bus_write(2'd3, 10'h3FF);
        bus_read(2'd3, v); check("edge_cleared", v, 10'h000);

        // Glitch on bit 5, 5 cycles wide
        @(negedge clk); in_port = 10'h020;
        wait_cycles(5);
        @(negedge clk); in_port = 10'h000;
        wait_cycles(SETTLE);
        bus_read(2'd0, v); check("glitch_data", v, 10'h000);
        bus_read(2'd3, v); check("glitch_edge", v, 10'h000);

        // Interrupt flow
        bus_write(2'd2, 10'h001);
        check("irq_before_press", irq, 0);
        @(negedge clk); in_port = 10'h001;
        wait_cycles(SETTLE);
        #1;
        check("irq_after_press", irq, 1);
        bus_write(2'd3, 10'h001);
        check("irq_after_clear", irq, 0);
        @(negedge clk); in_port = 10'h000;
        wait_cycles(SETTLE);
        #1;
        check("irq_after_release", irq, 1);

        // Clear/set collision on bit 1
        bus_write(2'd3, 10'h3FF);
        bus_write(2'd2, 10'h002);
        wait_cycles(2);
        begin : align
            int guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (r_phase != 2'd0 && guard < 8);
            check("align_timeout", (guard < 8), 1);
        end
        in_port = 10'h002;
        // deb[1] is accepted at the 12th rising edge after this point
        wait_cycles(11);
        bus_write(2'd3, 10'h002);
        bus_read(2'd3, v); check("collision_edge", v, 10'h002);
        bus_read(2'd0, v); check("collision_data", v, 10'h002);
        check("collision_irq", irq, 1);

        // Reset in the middle of a debounce
        @(negedge clk); in_port = 10'h3FF;
        wait_cycles(7);
        @(negedge clk); reset_n = 1'b0;
        #1;
        check("midreset_readdata", readdata, 0);
        check("midreset_irq", irq, 0);
        @(negedge clk); reset_n = 1'b1;
        bus_read(2'd0, v); check("postreset_data_early", v, 10'h000);
        wait_cycles(SETTLE);
        bus_read(2'd0, v); check("postreset_data", v, 10'h3FF);
        bus_read(2'd3, v); check("postreset_edge", v, 10'h3FF);
        check("postreset_irq", irq, 0);

        // Read mux
        bus_write(2'd1, 10'h3FF);
        bus_read(2'd1, v); check("rsvd_read", v, 10'h000);
        bus_write(2'd0, 10'h000);
        bus_read(2'd0, v); check("data_write_ignored", v, 10'h3FF);
        bus_write(2'd2, 10'h155);
        bus_read(2'd2, v); check("mask_readback", v, 10'h155);
        check("irq_mask_155", irq, 1);
        bus_write(2'd3, 10'h155);
        bus_read(2'd3, v); check("edge_partial_clear", v, 10'h2AA);
        check("irq_after_partial", irq, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
